// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC operand sequencer.
//   seq_state_e  : sequencer state encoding
//   *_DEF        : default parameter values for the sequencer and its buffer
//   IDX_W/ROW_W  : index widths for the default geometry
//   len_in_range : true when a requested vector length is 1..depth
package mac_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int ROWS_DEF   = 4;
  localparam int GAP_DEF    = 2;

  localparam int IDX_W = $clog2(DEPTH_DEF);
  localparam int ROW_W = $clog2(ROWS_DEF);

  function automatic logic len_in_range(input int len, input int depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/mac_operand_buf.sv
// Operand storage for the MAC sequencer: one input vector (DEPTH entries)
// and one weight tile (ROWS*DEPTH entries, addressed {row, idx}).
// Ports:
//   clk_i        clock
//   wr_en_i      write strobe (already qualified by the caller)
//   wr_sel_i     0 = input vector, 1 = weight tile
//   wr_addr_i    input: low bits are idx; weight: {row, idx}
//   wr_data_i    operand to store
//   rd_row_i     read row
//   rd_idx_i     read element index
//   rd_input_o   input[rd_idx_i]           (combinational)
//   rd_weight_o  weight[{rd_row_i,rd_idx_i}] (combinational)
// Contents are deliberately not reset.
module mac_operand_buf
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ROWS   = ROWS_DEF
) (
  input  logic                            clk_i,
  input  logic                            wr_en_i,
  input  logic                            wr_sel_i,
  input  logic [$clog2(ROWS*DEPTH)-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  input  logic [$clog2(ROWS)-1:0]         rd_row_i,
  input  logic [$clog2(DEPTH)-1:0]        rd_idx_i,
  output logic [DATA_W-1:0]               rd_input_o,
  output logic [DATA_W-1:0]               rd_weight_o
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] inp_mem [DEPTH];
  logic [DATA_W-1:0] wgt_mem [ROWS*DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_sel_i) begin
        wgt_mem[wr_addr_i] <= wr_data_i;
      end else begin
        inp_mem[wr_addr_i[IW-1:0]] <= wr_data_i;
      end
    end
  end

  // row*DEPTH + idx is a plain concatenation because DEPTH is a power of 2
  assign rd_input_o  = inp_mem[rd_idx_i];
  assign rd_weight_o = wgt_mem[{rd_row_i, rd_idx_i}];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds (input, weight) operand pairs to the DSP48 MAC, one pair per cycle,
// one row (dot product of length K) at a time with GAP idle cycles between
// rows so the MAC can drain its valid pipe.
// Optional feature: define SEQ_STALL_EN to add stall_i, which freezes the
// stream in RUN/GAP without losing or duplicating a pair.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wr_en_i/wr_sel_i/wr_addr_i/wr_data_i  operand buffer write port (IDLE only)
//   len_i                        K, sampled with an accepted start
//   start_i                      start pulse
//   stall_i                      stream freeze (SEQ_STALL_EN only)
//   busy_o, done_o               run status, 1-cycle done pulse
//   dsp_en_o, dsp_valid_o        MAC clock enable / pair valid
//   dsp_input_o, dsp_weight_o    operand pair (0 outside RUN)
//   row_first_o, row_last_o      row framing on the pair
//   row_idx_o                    row of the current pair
//
// state  | meaning
// S_IDLE | waiting for a start with a legal length; buffer writable
// S_RUN  | presenting pair (row_q, idx_q) to the output register
// S_GAP  | idle cycles between rows, gap_q counts down to 0
// S_DONE | tile finished; done_o follows one cycle later
//
// All outputs are registered from the current state, so each pair appears
// one cycle after the state that selects it.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic                            wr_sel_i,
  input  logic [$clog2(ROWS*DEPTH)-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  input  logic [$clog2(DEPTH):0]          len_i,
  input  logic                            start_i,
`ifdef SEQ_STALL_EN
  input  logic                            stall_i,
`endif
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            dsp_en_o,
  output logic                            dsp_valid_o,
  output logic [DATA_W-1:0]               dsp_input_o,
  output logic [DATA_W-1:0]               dsp_weight_o,
  output logic                            row_first_o,
  output logic                            row_last_o,
  output logic [$clog2(ROWS)-1:0]         row_idx_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2(GAP + 1);

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [RW-1:0]     row_q;
  logic [GW-1:0]     gap_q;
  logic [IW:0]       len_q;

  logic [IW-1:0]     last_idx;
  logic              last_row;
  logic              hold;
  logic              start_ok;
  logic              wr_ok;
  logic              pair_end;
  logic [DATA_W-1:0] rd_input;
  logic [DATA_W-1:0] rd_weight;

`ifdef SEQ_STALL_EN
  assign hold = stall_i && (state_q == S_RUN || state_q == S_GAP);
`else
  assign hold = 1'b0;
`endif

  assign last_idx = IW'(len_q - 1'b1);
  assign last_row = (row_q == RW'(ROWS - 1));
  assign pair_end = (state_q == S_RUN) && !hold && (idx_q == last_idx);

  // busy_o stays high through the cycle that shows done_o, while the state
  // is already back in IDLE; both starts and writes wait for it to drop.
  assign start_ok = start_i && (state_q == S_IDLE) && !busy_o &&
                    len_in_range(int'(len_i), DEPTH);
  assign wr_ok    = wr_en_i && (state_q == S_IDLE) && !busy_o;

  mac_operand_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ROWS   (ROWS)
  ) u_buf (
    .clk_i       (clk_i),
    .wr_en_i     (wr_ok),
    .wr_sel_i    (wr_sel_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_row_i    (row_q),
    .rd_idx_i    (idx_q),
    .rd_input_o  (rd_input),
    .rd_weight_o (rd_weight)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_RUN;
      S_RUN:  if (pair_end) state_d = last_row ? S_DONE : S_GAP;
      S_GAP:  if (!hold && gap_q == '0) state_d = S_RUN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Element/row/gap counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      row_q <= '0;
      gap_q <= '0;
      len_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            len_q <= len_i;
            idx_q <= '0;
            row_q <= '0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (idx_q == last_idx) begin
              idx_q <= '0;
              gap_q <= GW'(GAP - 1);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (!hold) begin
            if (gap_q == '0) begin
              row_q <= row_q + 1'b1;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        S_DONE: begin
          idx_q <= '0;
          row_q <= '0;
        end
        default: begin
          idx_q <= '0;
          row_q <= '0;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dsp_en_o     <= 1'b0;
      dsp_valid_o  <= 1'b0;
      dsp_input_o  <= '0;
      dsp_weight_o <= '0;
      row_first_o  <= 1'b0;
      row_last_o   <= 1'b0;
      row_idx_o    <= '0;
    end else begin
      busy_o <= (state_q != S_IDLE) || start_ok;
      done_o <= (state_q == S_DONE);
      if (state_q == S_RUN && !hold) begin
        dsp_en_o     <= 1'b1;
        dsp_valid_o  <= 1'b1;
        dsp_input_o  <= rd_input;
        dsp_weight_o <= rd_weight;
        row_first_o  <= (idx_q == '0);
        row_last_o   <= (idx_q == last_idx);
        row_idx_o    <= row_q;
      end else if (hold) begin
        // frozen: operands and row keep their last value, nothing is live
        dsp_en_o     <= 1'b0;
        dsp_valid_o  <= 1'b0;
        row_first_o  <= 1'b0;
        row_last_o   <= 1'b0;
      end else begin
        dsp_en_o     <= 1'b0;
        dsp_valid_o  <= 1'b0;
        dsp_input_o  <= '0;
        dsp_weight_o <= '0;
        row_first_o  <= 1'b0;
        row_last_o   <= 1'b0;
        row_idx_o    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;
  import mac_seq_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ROWS   = 4;
  localparam int GAP    = 2;
  localparam int AW     = $clog2(ROWS*DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [IDX_W:0]    len;
  logic              start;
  logic              busy, done, dsp_en, dsp_valid, row_first, row_last;
  logic [7:0]        dsp_input, dsp_weight;
  logic [ROW_W-1:0]  row_idx;
`ifdef SEQ_STALL_EN
  logic              stall;
`endif

  int checks = 0;
  int errors = 0;

  // reference contents of the operand buffers
  logic [7:0] m_in [DEPTH];
  logic [7:0] m_w  [ROWS][DEPTH];

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ROWS   (ROWS),
    .GAP    (GAP)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_sel_i     (wr_sel),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .len_i        (len),
    .start_i      (start),
`ifdef SEQ_STALL_EN
    .stall_i      (stall),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .dsp_en_o     (dsp_en),
    .dsp_valid_o  (dsp_valid),
    .dsp_input_o  (dsp_input),
    .dsp_weight_o (dsp_weight),
    .row_first_o  (row_first),
    .row_last_o   (row_last),
    .row_idx_o    (row_idx)
  );

  function automatic logic [23:0] observed();
    return {busy, done, dsp_en, dsp_valid, row_first, row_last, row_idx, dsp_input, dsp_weight};
  endfunction

  // Expected outputs n cycles after the edge that accepted a start of length k.
  // Tile layout: row r, element i is live at 1 + r*(k+GAP) + i; done follows the tile.
  function automatic logic [23:0] exp_vec(input int k, input int n);
    int total, rel, r, i;
    logic b, d, v, f, l;
    logic [ROW_W-1:0] ri;
    logic [7:0] a, w;
    total = ROWS*k + (ROWS-1)*GAP + 1;
    b = (n <= total);
    d = (n == total);
    v = 1'b0; f = 1'b0; l = 1'b0; ri = '0; a = '0; w = '0;
    if (n >= 1 && n < total) begin
      rel = n - 1;
      r = rel / (k + GAP);
      i = rel % (k + GAP);
      if (i < k) begin
        v  = 1'b1;
        f  = (i == 0);
        l  = (i == k-1);
        ri = ROW_W'(r);
        a  = m_in[i];
        w  = m_w[r][i];
      end
    end
    return {b, d, v, v, f, l, ri, a, w};
  endfunction

  task automatic wr(input logic sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_in(input int i, input logic [7:0] d);
    wr(1'b0, i, d);
    m_in[i] = d;
  endtask

  task automatic load_w(input int r, input int i, input logic [7:0] d);
    wr(1'b1, (r << IDX_W) | i, d);
    m_w[r][i] = d;
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) load_in(i, 8'($urandom));
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < DEPTH; i++) load_w(r, i, 8'($urandom));
  endtask

  task automatic load_scen2();
    logic [7:0] v [4];
    v[0] = 8'sd1; v[1] = -8'sd2; v[2] = 8'sd3; v[3] = 8'sd4;
    for (int i = 0; i < 4; i++) load_in(i, v[i]);
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < 4; i++) load_w(r, i, 8'(r));
  endtask

  // Start a run of length k and compare every cycle until busy should drop.
  // poke_at >= 0: at that cycle also pulse start and write input[0]=127
  // (both must be ignored while busy).
  task automatic run_check(input int k, input string tag, input int poke_at);
    int total;
    logic [23:0] g, e;
    total = ROWS*k + (ROWS-1)*GAP + 1;
    len = (IDX_W+1)'(k);
    start = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= total + 1; n++) begin
      g = observed();
      e = exp_vec(k, n);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s k=%0d cyc %0d got %h expected %h", tag, k, n, g, e);
      end
      if (n == poke_at) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd127;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (observed() !== 24'h0) begin
      errors++;
      $display("FAIL reset_hold got %h expected 000000", observed());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== 24'h0) begin
      errors++;
      $display("FAIL reset_release got %h expected 000000", observed());
    end
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? '0 : (IDX_W+1)'(DEPTH + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (observed() !== 24'h0) begin
          errors++;
          $display("FAIL bad_len len=%0d cyc %0d got %h expected 000000", len, c, observed());
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_stream();
    load_scen2();
    run_check(4, "scen2_k4", -1);
    load_random();
    run_check(1, "k1", -1);
  endtask

  task automatic test_busy_ignore();
    int k;
    load_random();
    load_in(0, 8'd5);
    k = 3;
    run_check(k, "busy_poke", 4);
    run_check(k, "after_poke", -1);
  endtask

  task automatic test_write_start();
    logic [7:0] d;
    int k;
    d = m_in[0] ^ 8'h5A;
    k = int'($urandom_range(1, DEPTH));
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = d;
    m_in[0] = d;
    run_check(k, "write_with_start", -1);
  endtask

  task automatic test_extremes_abort();
    int k;
    logic [23:0] g, e;
    for (int i = 0; i < 4; i++) load_in(i, 8'h80);
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < 4; i++) load_w(r, i, 8'h80);
    run_check(4, "extreme", -1);
    k = 4;
    len = (IDX_W+1)'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 1 + 2*(k+GAP); n++) begin
      g = observed();
      e = exp_vec(k, n);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort_pre cyc %0d got %h expected %h", n, g, e);
      end
      if (n < 1 + 2*(k+GAP)) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (observed() !== 24'h0) begin
      errors++;
      $display("FAIL abort_reset got %h expected 000000", observed());
    end
    for (int c = 0; c < ROWS*k + ROWS*GAP; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, dsp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL abort_quiet cyc %0d got busy/done/valid %b expected 000", c, {busy, done, dsp_valid});
      end
    end
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 3; it++) begin
      load_random();
      run_check(int'($urandom_range(1, DEPTH)), "random", -1);
    end
  endtask

`ifdef SEQ_STALL_EN
  task automatic test_stall();
    int k, total, done_at, seen, gapc, idx;
    logic [19:0] q[$];
    logic [19:0] e;
    k = 4;
    load_scen2();
    total = ROWS*k + (ROWS-1)*GAP + 1;
    len = (IDX_W+1)'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1; seen = 0; gapc = 0;
    for (int n = 0; n <= total + 5; n++) begin
      if (dsp_valid) begin
        q.push_back({row_first, row_last, row_idx, dsp_input, dsp_weight});
        seen++;
      end else if (seen == 2) begin
        gapc++;
      end
      if (done && done_at < 0) done_at = n;
      stall = (n >= 2 && n < 5);
      @(negedge clk);
    end
    stall = 1'b0;
    checks++;
    if (q.size() != ROWS*k) begin
      errors++;
      $display("FAIL stall_count got %0d expected %0d", q.size(), ROWS*k);
    end
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < k; i++) begin
        idx = r*k + i;
        e = {(i == 0), (i == k-1), ROW_W'(r), m_in[i], m_w[r][i]};
        if (idx < q.size()) begin
          checks++;
          if (q[idx] !== e) begin
            errors++;
            $display("FAIL stall_pair %0d got %h expected %h", idx, q[idx], e);
          end
        end
      end
    checks++;
    if (done_at != total + 3) begin
      errors++;
      $display("FAIL stall_done got %0d expected %0d", done_at, total + 3);
    end
    checks++;
    if (gapc != 3) begin
      errors++;
      $display("FAIL stall_gap got %0d expected 3", gapc);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0;
`ifdef SEQ_STALL_EN
    stall = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) m_in[i] = '0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < DEPTH; i++) m_w[r][i] = '0;
    test_reset();
    test_stream();
    test_busy_ignore();
    test_write_start();
    test_extremes_abort();
    test_random_runs();
`ifdef SEQ_STALL_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
